// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file with dual write ports, per-entry pending
//            bits and a sequential bulk-clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NRP     = 2,
  parameter bit R0_ZERO = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NRP*AW-1:0] raddr,
  output logic [NRP*DW-1:0] rdata,
  output logic [NRP-1:0]    rpend,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [DW-1:0]     wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic [DW-1:0]     wdata1,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int            NREG   = 2**AW;
  localparam logic [AW-1:0] c_last = {AW{1'b1}};

  generate
    if (NRP < 1 || NRP > 4) begin : g_bad_nrp
      $error("regfile_mp: NRP must be in 1..4");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t          r_state, w_state_n;
  logic [AW-1:0]   r_idx, w_idx_n;
  logic            w_clearing;
  logic            w_we0, w_we1, w_iss;
  logic [DW-1:0]   r_mem [NREG];
  logic [NREG-1:0] r_pend, w_pend_n;

  assign w_clearing = (r_state == S_CLEAR);
  assign clr_busy   = w_clearing;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_n = S_CLEAR;
          w_idx_n   = '0;
        end
      end
      S_CLEAR: begin
        // Index wraps to 0 naturally when leaving from the last entry.
        w_idx_n = r_idx + AW'(1);
        if (r_idx == c_last) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign w_we0 = we0 && !w_clearing && !(R0_ZERO && waddr0 == '0);
  assign w_we1 = we1 && !w_clearing && !(R0_ZERO && waddr1 == '0);
  assign w_iss = iss_valid && !w_clearing && !(R0_ZERO && iss_addr == '0);

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_clearing) begin
      r_mem[r_idx] <= '0;
    end else begin
      if (w_we0) r_mem[waddr0] <= wdata0;
      if (w_we1) r_mem[waddr1] <= wdata1;
    end
  end

  // A new reservation beats a writeback retiring the previous one.
  always_comb begin
    w_pend_n = r_pend;
    for (int i = 0; i < NREG; i++) begin
      if (w_clearing) begin
        if (r_idx == AW'(i)) w_pend_n[i] = 1'b0;
      end else if (w_iss && iss_addr == AW'(i)) begin
        w_pend_n[i] = 1'b1;
      end else if ((w_we0 && waddr0 == AW'(i)) || (w_we1 && waddr1 == AW'(i))) begin
        w_pend_n[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_pend <= '0;
    else         r_pend <= w_pend_n;
  end

  generate
    for (genvar k = 0; k < NRP; k++) begin : g_rd
      logic [AW-1:0] w_a;
      logic [DW-1:0] w_d;
      logic          w_p;
      logic          w_hit0, w_hit1;

      assign w_a    = raddr[k*AW +: AW];
      assign w_hit0 = BYPASS && we0 && (waddr0 == w_a);
      assign w_hit1 = BYPASS && we1 && (waddr1 == w_a);

      always_comb begin
        w_d = r_mem[w_a];
        w_p = r_pend[w_a];
        if (w_clearing || (R0_ZERO && w_a == '0)) begin
          w_d = '0;
          w_p = 1'b0;
        end else if (w_hit1) begin
          w_d = wdata1;
          w_p = 1'b0;
        end else if (w_hit0) begin
          w_d = wdata0;
          w_p = 1'b0;
        end
      end

      assign rdata[k*DW +: DW] = w_d;
      assign rpend[k]          = w_p;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Directed self-checking bench for regfile_mp (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NRP  = 2;
  localparam int NREG = 32;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NRP*AW-1:0] raddr = '0;
  logic [NRP*DW-1:0] rdata;
  logic [NRP-1:0]    rpend;
  logic              we0 = 1'b0, we1 = 1'b0, iss_valid = 1'b0, clr_req = 1'b0;
  logic [AW-1:0]     waddr0 = '0, waddr1 = '0, iss_addr = '0;
  logic [DW-1:0]     wdata0 = '0, wdata1 = '0;
  logic              clr_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DW(DW), .AW(AW), .NRP(NRP), .R0_ZERO(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata), .rpend(rpend),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0; clr_req = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return rdata[k*DW +: DW];
  endfunction

  // Counts consecutive busy cycles starting now; gives up after a bound.
  task automatic count_busy(output int n, output bit timed_out);
    n = 0;
    timed_out = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (!clr_busy) begin
        timed_out = 1'b0;
        break;
      end
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    set_rd(5'd3, 5'd4);
    #1;
    checks++;
    if (rdata !== '0 || rpend !== '0 || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state rdata=%h rpend=%b busy=%b expected 0/0/0", rdata, rpend, clr_busy);
    end
    step();
    resetn = 1'b1;
    we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hABCD;
    iss_valid = 1'b1; iss_addr = 5'd4;
    step();
    idle();
    #1;
    checks++;
    if (rd(0) !== 32'hABCD || rpend[1] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_write r3=%h pend4=%b expected 0000abcd/1", rd(0), rpend[1]);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (rdata !== '0 || rpend !== '0 || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset rdata=%h rpend=%b busy=%b expected 0/0/0", rdata, rpend, clr_busy);
    end
    step();
    resetn = 1'b1;
  endtask

  task automatic test_dual_write();
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1111;
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h2222;
    set_rd(5'd5, 5'd5);
    #1;
    checks++;
    if (rd(0) !== 32'h2222) begin
      errors++;
      $display("FAIL dual_bypass rdata=%h expected 00002222", rd(0));
    end
    step();
    idle();
    #1;
    checks++;
    if (rd(0) !== 32'h2222) begin
      errors++;
      $display("FAIL dual_store rdata=%h expected 00002222", rd(0));
    end
    we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h6666;
    set_rd(5'd6, 5'd5);
    #1;
    checks++;
    if (rd(0) !== 32'h6666 || rd(1) !== 32'h2222) begin
      errors++;
      $display("FAIL bypass_port0 p0=%h p1=%h expected 00006666/00002222", rd(0), rd(1));
    end
    step();
    idle();
    #1;
    checks++;
    if (rd(0) !== 32'h6666) begin
      errors++;
      $display("FAIL store_port0 rdata=%h expected 00006666", rd(0));
    end
  endtask

  task automatic test_r0();
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hDEAD;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hBEEF;
    iss_valid = 1'b1; iss_addr = 5'd0;
    set_rd(5'd0, 5'd0);
    #1;
    checks++;
    if (rdata !== '0 || rpend !== '0) begin
      errors++;
      $display("FAIL r0_write_cycle rdata=%h rpend=%b expected 0/0", rdata, rpend);
    end
    step();
    idle();
    repeat (3) step();
    checks++;
    if (rdata !== '0 || rpend !== '0) begin
      errors++;
      $display("FAIL r0_after rdata=%h rpend=%b expected 0/0", rdata, rpend);
    end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_addr = 5'd7;
    set_rd(5'd7, 5'd9);
    step();
    idle();
    #1;
    checks++;
    if (rpend !== 2'b01) begin
      errors++;
      $display("FAIL issue_visible rpend=%b expected 01", rpend);
    end
    iss_valid = 1'b1; iss_addr = 5'd7;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h55;
    #1;
    checks++;
    if (rd(0) !== 32'h55 || rpend[0] !== 1'b0) begin
      errors++;
      $display("FAIL race_cycle rdata=%h pend=%b expected 00000055/0", rd(0), rpend[0]);
    end
    step();
    idle();
    #1;
    checks++;
    if (rd(0) !== 32'h55 || rpend[0] !== 1'b1) begin
      errors++;
      $display("FAIL race_set_wins rdata=%h pend=%b expected 00000055/1", rd(0), rpend[0]);
    end
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h77;
    step();
    idle();
    #1;
    checks++;
    if (rd(0) !== 32'h77 || rpend[0] !== 1'b0) begin
      errors++;
      $display("FAIL write_clears_pend rdata=%h pend=%b expected 00000077/0", rd(0), rpend[0]);
    end
  endtask

  task automatic test_bulk_clear();
    int  n;
    int  bad;
    bit  done;
    for (int i = 0; i < NREG; i++) begin
      we0 = 1'b1; waddr0 = AW'(i); wdata0 = 32'h100 + i;
      iss_valid = 1'b1; iss_addr = AW'(i);
      step();
    end
    idle();
    set_rd(5'd31, 5'd1);
    #1;
    checks++;
    if (rd(0) !== 32'h11F || rd(1) !== 32'h101 || rpend !== 2'b11) begin
      errors++;
      $display("FAIL fill r31=%h r1=%h rpend=%b expected 0000011f/00000101/11", rd(0), rd(1), rpend);
    end
    clr_req = 1'b1;
    step();
    idle();
    n = 0; bad = 0; done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!clr_busy) begin
        done = 1'b1;
        break;
      end
      n++;
      we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hBAD;
      we0 = 1'b1; waddr0 = AW'(c); wdata0 = 32'hBAD0 + c;
      iss_valid = 1'b1; iss_addr = 5'd30;
      set_rd(AW'(c), 5'd30);
      #1;
      if (rdata !== '0 || rpend !== '0) bad++;
      step();
    end
    idle();
    we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'hC0DE;
    step();
    idle();
    checks++;
    if (!done || n != NREG) begin
      errors++;
      $display("FAIL clear_length busy_cycles=%0d ended=%b expected 32/1", n, done);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_reads_zero nonzero_cycles=%0d expected 0", bad);
    end
    set_rd(5'd12, 5'd12);
    #1;
    checks++;
    if (rd(0) !== 32'hC0DE) begin
      errors++;
      $display("FAIL write_after_clear r12=%h expected 0000c0de", rd(0));
    end
    bad = 0;
    for (int a = 0; a < NREG; a++) begin
      if (a == 12) continue;
      set_rd(AW'(a), AW'(a));
      #1;
      if (rd(0) !== '0 || rpend[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL cleared_contents nonzero_entries=%0d expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    bit to;
    clr_req = 1'b1;
    step();
    idle();
    repeat (10) step();
    checks++;
    if (clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_clear_busy busy=%b expected 1", clr_busy);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear busy=%b expected 0", clr_busy);
    end
    step();
    resetn = 1'b1;
    we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'h2020;
    step();
    idle();
    set_rd(5'd20, 5'd20);
    #1;
    checks++;
    if (rd(0) !== 32'h2020) begin
      errors++;
      $display("FAIL write_after_reset r20=%h expected 00002020", rd(0));
    end
    clr_req = 1'b1;
    step();
    idle();
    count_busy(n, to);
    checks++;
    if (to || n != NREG) begin
      errors++;
      $display("FAIL reclear_length busy_cycles=%0d timeout=%b expected 32/0", n, to);
    end
    #1;
    checks++;
    if (rd(0) !== '0) begin
      errors++;
      $display("FAIL reclear_contents r20=%h expected 0", rd(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dual_write();
    test_r0();
    test_scoreboard();
    test_bulk_clear();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with a dual write port, per-register pending (scoreboard) bits and a sequential bulk-clear engine. It is the next-generation general register file for the pipelined core. Decode reads it and issues destination reservations into it. The EX/MEM and WB stages write it back. The core's stall logic consumes the pending flags and the clear-busy indication.

## Interface
- `DW`, 32, data width of each register
- `AW`, 5, address width; the file holds `NREG = 2**AW` entries
- `NRP`, 2, number of read ports (1..4)
- `R0_ZERO`, 1, when 1, entry 0 reads as zero, ignores writes and never becomes pending
- `BYPASS`, 1, when 1, a same-cycle write is forwarded to matching read ports

- `clk`  in  1  single clock; all state updates on the rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `raddr`  in  NRP*AW  read addresses; port k uses bits [k*AW +: AW]
- `rdata`  out  NRP*DW  read data, port k at [k*DW +: DW]; combinational
- `rpend`  out  NRP  pending flag for each read address; combinational
- `we0`, `waddr0`, `wdata0`  in  1/AW/DW  write port 0 (low priority)
- `we1`, `waddr1`, `wdata1`  in  1/AW/DW  write port 1 (high priority)
- `iss_valid`, `iss_addr`  in  1/AW  reserve a destination: sets its pending bit
- `clr_req`  in  1  start bulk clear of all entries and pending bits
- `clr_busy`  out  1  bulk clear in progress

## Operation
- Reset (asynchronous, `resetn`=0):
  - all entries are 0 and all pending bits are 0
  - the clear FSM is in IDLE with its index at 0
  - `clr_busy`=0
  - `rdata` and `rpend` follow from the cleared state
- Writes: an entry updates at the clock edge when its write enable is 1.
  - If `we0` and `we1` target the same address, `wdata1` is stored.
  - A write to address 0 is dropped when `R0_ZERO`=1.
- Read data for port k:
  - If `R0_ZERO` and `raddr`=0: 0.
  - Otherwise, if `BYPASS` and `we1` with `waddr1`==`raddr`: `wdata1`.
  - Otherwise, if `BYPASS` and `we0` with `waddr0`==`raddr`: `wdata0`.
  - Otherwise: the stored value.
- Pending bits:
  - Set at the edge when `iss_valid` is 1 for `iss_addr`.
  - Cleared at the edge by any active write (`we0` or `we1`) to that address.
  - When a set and a clear hit the same address in the same cycle, the set wins (the newer reservation survives).
  - Address 0 never sets when `R0_ZERO`=1.
- `rpend[k]` shows the registered pending bit of `raddr` k.
  - With `BYPASS`=1, it reads 0 for that port in any cycle where a write to that address is active.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR when `clr_req`=1; the index loads 0.
  - In CLEAR, each cycle zeroes entry `idx` and its pending bit, then increments `idx`.
  - CLEAR → IDLE after the edge that clears entry NREG-1; the index wraps to 0.
  - `clr_req` is ignored while in CLEAR.
- During CLEAR:
  - `clr_busy`=1.
  - Writes and issues are ignored.
  - All `rdata` read 0 and all `rpend` read 0.
- Reset mid-clear: returns to IDLE immediately with everything zeroed.
- Width rules: addresses are unsigned with no wrap beyond NREG. `NRP` outside 1..4 is a parameter error and stops elaboration.

## Timing
- Read latency is 0 cycles (combinational from `raddr`, the write ports and the stored state).
- Write latency is 1 edge. With `BYPASS`=0, a read of the same address in the write cycle returns the old value.
- Issue is visible on `rpend` from the cycle after `iss_valid`.
- Clear runs for exactly NREG cycles:
  - `clr_busy` rises the cycle after the `clr_req` edge and stays high for NREG cycles.
  - The first write accepted after the clear lands in the cycle `clr_busy` returns to 0.
- No handshake on the write or issue ports; the producer holds nothing.

## Test plan
- Reset then read: `resetn` low mid-cycle → all `rdata`=0 and `rpend`=0 immediately, without waiting for a clock edge.
- Dual-write conflict: `we0`/`we1` both to r5 with 0x1111/0x2222 → r5 reads 0x2222 next cycle. In the write cycle with `BYPASS`=1, `rdata`=0x2222.
- R0 protection: write 0xDEAD to r0 and issue r0 → r0 reads 0 and `rpend` stays 0 forever.
- Scoreboard race: r7 pending; same cycle `iss_valid` r7 and `we1` r7=0x55 → r7 stores 0x55 and is still pending next cycle. A later `we0` to r7 clears pending.
- Bulk clear: fill all 32 entries, pulse `clr_req`, drive writes throughout →
  - `clr_busy` is high for exactly 32 cycles
  - all `rdata` read 0 during the clear
  - writes during the clear are lost
  - all entries read 0 afterwards
  - a write issued on the first cycle after `clr_busy` falls sticks.
- Reset mid-clear: assert `resetn`=0 at idx=10 → `clr_busy`=0 at once, and the next `clr_req` starts at idx 0 and runs a full 32 cycles.
